// File: rtl/rsc_encoder.sv
// LTE constituent RSC encoder (g0=1+D^2+D^3, g1=1+D+D^3) emitting alternating systematic/parity LLR words.
// Build option RSC_TAIL_EN appends the three trellis-termination tail pairs.
module rsc_encoder #(
  parameter logic signed [15:0] AMP        = 16'sd1024,
  parameter int unsigned        MAX_BLKLEN = 6144
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        blklen,
  input  logic               valid_blklen,
  input  logic               bit_in,
  input  logic               valid_bit,
  output logic               ready_bit,
  output logic signed [15:0] out,
  output logic               valid_out,
  input  logic               ready_out,
  output logic               out_par,
  output logic               out_last,
  output logic               err_blklen
);

  localparam logic [15:0] MAX_K = 16'(MAX_BLKLEN);

`ifdef RSC_TAIL_EN
  typedef enum logic [2:0] {IDLE, SYS, PAR, TAIL_SYS, TAIL_PAR} state_t;
  logic [1:0] tail_cnt;
`else
  typedef enum logic [1:0] {IDLE, SYS, PAR} state_t;
`endif

  state_t      state;
  logic [12:0] k;
  logic [12:0] cnt;
  logic        s1, s2, s3;
  logic        par_q;
  logic        slot_free;
  logic        fb;

  assign slot_free = !valid_out || ready_out;
  assign ready_bit = (state == SYS) && slot_free;
  assign fb        = bit_in ^ s2 ^ s3;

  function automatic logic signed [15:0] map_llr(input logic b);
    return b ? -AMP : AMP;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      k          <= '0;
      cnt        <= '0;
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      par_q      <= 1'b0;
      out        <= '0;
      valid_out  <= 1'b0;
      out_par    <= 1'b0;
      out_last   <= 1'b0;
      err_blklen <= 1'b0;
`ifdef RSC_TAIL_EN
      tail_cnt   <= '0;
`endif
    end else begin
      err_blklen <= 1'b0;
      if (valid_out && ready_out)
        valid_out <= 1'b0;
      case (state)
        // A new block is only taken once the previous final word has left the output register.
        IDLE: if (valid_blklen && !valid_out) begin
          if (blklen != '0 && blklen <= MAX_K) begin
            k     <= blklen[12:0];
            cnt   <= '0;
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            state <= SYS;
          end else begin
            err_blklen <= 1'b1;
          end
        end
        SYS: if (valid_bit && slot_free) begin
          out       <= map_llr(bit_in);
          out_par   <= 1'b0;
          out_last  <= 1'b0;
          valid_out <= 1'b1;
          par_q     <= fb ^ s1 ^ s3;
          s3        <= s2;
          s2        <= s1;
          s1        <= fb;
          state     <= PAR;
        end
        PAR: if (slot_free) begin
          out       <= map_llr(par_q);
          out_par   <= 1'b1;
          valid_out <= 1'b1;
          cnt       <= cnt + 13'd1;
          if (cnt + 13'd1 == k) begin
`ifdef RSC_TAIL_EN
            out_last <= 1'b0;
            tail_cnt <= '0;
            state    <= TAIL_SYS;
`else
            out_last <= 1'b1;
            state    <= IDLE;
`endif
          end else begin
            out_last <= 1'b0;
            state    <= SYS;
          end
        end
`ifdef RSC_TAIL_EN
        // Tail input u = s2^s3 cancels the feedback, so a=0 and parity reduces to s1^s3.
        TAIL_SYS: if (slot_free) begin
          out       <= map_llr(s2 ^ s3);
          out_par   <= 1'b0;
          out_last  <= 1'b0;
          valid_out <= 1'b1;
          par_q     <= s1 ^ s3;
          s3        <= s2;
          s2        <= s1;
          s1        <= 1'b0;
          state     <= TAIL_PAR;
        end
        TAIL_PAR: if (slot_free) begin
          out       <= map_llr(par_q);
          out_par   <= 1'b1;
          valid_out <= 1'b1;
          out_last  <= (tail_cnt == 2'd2);
          tail_cnt  <= tail_cnt + 2'd1;
          state     <= (tail_cnt == 2'd2) ? IDLE : TAIL_SYS;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsc_encoder.sv
// Scoreboard bench for rsc_encoder: stimulus pushes expected words, a negedge monitor pops and compares.
// Expected tail behaviour follows whether RSC_TAIL_EN is defined for the build.
module tb_rsc_encoder;

`ifdef RSC_TAIL_EN
  localparam bit TAIL = 1'b1;
`else
  localparam bit TAIL = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [15:0]        blklen;
  logic               valid_blklen;
  logic               bit_in;
  logic               valid_bit;
  logic               ready_bit;
  logic signed [15:0] out;
  logic               valid_out;
  logic               ready_out = 1'b1;
  logic               out_par;
  logic               out_last;
  logic               err_blklen;

  rsc_encoder #(.AMP(16'sd1024), .MAX_BLKLEN(6144)) dut (
    .clk(clk), .rst(rst), .blklen(blklen), .valid_blklen(valid_blklen),
    .bit_in(bit_in), .valid_bit(valid_bit), .ready_bit(ready_bit),
    .out(out), .valid_out(valid_out), .ready_out(ready_out),
    .out_par(out_par), .out_last(out_last), .err_blklen(err_blklen)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] w;
    logic        par;
    logic        last;
  } word_t;

  word_t exp_q[$];
  bit    stim[$];
  int    checks   = 0;
  int    failures = 0;
  bit    stall_en = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_word(input int w, input bit par, input bit last);
    word_t e;
    e.w    = 16'(w);
    e.par  = par;
    e.last = last;
    exp_q.push_back(e);
  endtask

  // Reference trellis: a = u^s2^s3, z = a^s1^s3; tail only when the whole block was sent.
  task automatic push_model(input int k);
    bit s1 = 0, s2 = 0, s3 = 0, a, z, u;
    int n = stim.size();
    for (int i = 0; i < n; i++) begin
      u = stim[i];
      a = u ^ s2 ^ s3;
      z = a ^ s1 ^ s3;
      push_word(u ? -1024 : 1024, 1'b0, 1'b0);
      push_word(z ? -1024 : 1024, 1'b1, !TAIL && (i == k - 1));
      s3 = s2; s2 = s1; s1 = a;
    end
    if (TAIL && n == k) begin
      for (int t = 0; t < 3; t++) begin
        u = s2 ^ s3;
        z = s1 ^ s3;
        push_word(u ? -1024 : 1024, 1'b0, 1'b0);
        push_word(z ? -1024 : 1024, 1'b1, t == 2);
        s3 = s2; s2 = s1; s1 = 1'b0;
      end
    end
  endtask

  task automatic push_k4();
    int base[8] = '{-1024, -1024, 1024, -1024, -1024, 1024, -1024, -1024};
    for (int i = 0; i < 8; i++) push_word(base[i], (i % 2) == 1, !TAIL && i == 7);
    if (TAIL) for (int i = 0; i < 6; i++) push_word(1024, (i % 2) == 1, i == 5);
  endtask

  task automatic push_k1();
    int tl[6] = '{1024, -1024, -1024, 1024, -1024, -1024};
    push_word(-1024, 1'b0, 1'b0);
    push_word(-1024, 1'b1, !TAIL);
    if (TAIL) for (int i = 0; i < 6; i++) push_word(tl[i], (i % 2) == 1, i == 5);
  endtask

  // Monitor: a handshake is decided at the next posedge, so valid&&ready at negedge means a word is taken.
  logic  held_v = 1'b0;
  word_t held;
  always @(negedge clk) begin
    word_t e;
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v)
        check("hold_stable", int'({out, out_par, out_last}), int'(held));
      if (valid_out && ready_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", int'(out), 99999);
        end else begin
          e = exp_q.pop_front();
          check("word_value", int'(out), int'($signed(e.w)));
          check("word_par", int'(out_par), int'(e.par));
          check("word_last", int'(out_last), int'(e.last));
        end
      end
      held_v = valid_out && !ready_out;
      held   = {out, out_par, out_last};
    end
  end

  always @(posedge clk) begin
    #1;
    ready_out = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out"}, int'(out), 0);
    check({tag, "_valid_out"}, int'(valid_out), 0);
    check({tag, "_ready_bit"}, int'(ready_bit), 0);
    check({tag, "_out_par"}, int'(out_par), 0);
    check({tag, "_out_last"}, int'(out_last), 0);
    check({tag, "_err_blklen"}, int'(err_blklen), 0);
  endtask

  task automatic start_block(input int k);
    @(posedge clk); #1;
    blklen       = 16'(k);
    valid_blklen = 1'b1;
    @(posedge clk); #1;
    valid_blklen = 1'b0;
    #1 check("ready_after_blklen", int'(ready_bit), 1);
  endtask

  task automatic send_bits(input int n);
    bit acc;
    for (int i = 0; i < n; i++) begin
      bit_in    = stim[i];
      valid_bit = 1'b1;
      acc       = 1'b0;
      for (int c = 0; c < 200 && !acc; c++) begin
        @(negedge clk);
        acc = ready_bit;
        @(posedge clk); #1;
      end
      if (!acc) begin
        check("bit_accept_timeout", 0, 1);
        break;
      end
    end
    valid_bit = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int c = 0; c < budget && (exp_q.size() != 0 || valid_out); c++) begin
      @(posedge clk); #2;
    end
    if (exp_q.size() != 0 || valid_out) begin
      check("drain_timeout_words_left", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic bad_blklen(input int k);
    @(posedge clk); #1;
    blklen       = 16'(k);
    valid_blklen = 1'b1;
    @(posedge clk); #1;
    valid_blklen = 1'b0;
    check("err_pulse_high", int'(err_blklen), 1);
    check("err_ready_low", int'(ready_bit), 0);
    @(posedge clk); #1;
    check("err_pulse_end", int'(err_blklen), 0);
    check("err_ready_stays_low", int'(ready_bit), 0);
  endtask

  task automatic run_k4();
    stim.delete();
    stim.push_back(1'b1); stim.push_back(1'b0); stim.push_back(1'b1); stim.push_back(1'b1);
    push_k4();
    start_block(4);
    send_bits(4);
    wait_drain(200);
  endtask

  task automatic random_stim(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(1'($urandom));
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; blklen = '0; valid_blklen = 1'b0; bit_in = 1'b0; valid_bit = 1'b0;
    repeat (2) @(posedge clk); #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    run_k4();

    stim.delete();
    stim.push_back(1'b1);
    push_k1();
    start_block(1);
    send_bits(1);
    wait_drain(200);

    bad_blklen(0);
    bad_blklen(6145);

    random_stim(512);
    push_model(512);
    stall_en = 1'b1;
    start_block(512);
    send_bits(512);
    wait_drain(20000);
    stall_en = 1'b0;

    random_stim(6144);
    push_model(6144);
    start_block(6144);
    send_bits(6144);
    wait_drain(20000);

    random_stim(100);
    push_model(512);
    start_block(512);
    send_bits(100);
    wait_drain(200);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midblock_reset");
    rst = 1'b0;

    run_k4();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rsc_encoder.md
# rsc_encoder

LTE constituent RSC encoder and soft-symbol source for the SISO decoder path. Accepts a block length, then one information bit per handshake, and emits the systematic/parity word stream in the same format the decoder consumes on `in`/`valid_in`: alternating systematic and parity 16-bit signed LLR words. Used as the on-chip transmitter end for loopback, and to generate decoder stimulus without file I/O.

## Interface
Parameters:
- `AMP`, 16'sd1024: LLR magnitude; bit 0 maps to +AMP, bit 1 maps to −AMP (two's complement).
- `MAX_BLKLEN`, 6144: largest accepted block length.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `blklen`  in  16  block length K, sampled when `valid_blklen`=1.
- `valid_blklen`  in  1  one-cycle strobe starting a block.
- `bit_in`  in  1  information bit.
- `valid_bit`  in  1  `bit_in` valid.
- `ready_bit`  out  1  encoder accepts a bit this cycle.
- `out`  out  16  signed LLR word, systematic or parity.
- `valid_out`  out  1  `out` valid.
- `ready_out`  in  1  downstream accepts `out`.
- `out_par`  out  1  1 = current word is parity, 0 = systematic.
- `out_last`  out  1  final word of the block.
- `err_blklen`  out  1  one-cycle pulse when a `blklen` is rejected.

## Operation
- Trellis: g0 = 1+D²+D³ (feedback), g1 = 1+D+D³. State s1,s2,s3, zero at block start.
  - Feedback a = u ^ s2 ^ s3; parity z = a ^ s1 ^ s3; update s3←s2, s2←s1, s1←a.
- FSM states: IDLE, SYS, PAR, TAIL_SYS, TAIL_PAR.
  - IDLE: on `valid_blklen` with 1 ≤ blklen ≤ MAX_BLKLEN: latch K, clear state, clear bit counter, go SYS. Out-of-range value: pulse `err_blklen`, stay IDLE.
  - SYS: `ready_bit` = (!`valid_out` || `ready_out`). On accept: load out = map(u), `out_par`=0; compute z into parity register; update trellis; go PAR.
  - PAR: when output slot free, load out = map(z), `out_par`=1; increment count; if count = K, go TAIL_SYS (or IDLE when tail disabled), else go SYS.
  - TAIL_SYS: u = s2 ^ s3 (forces a=0); load map(u); compute z = s1 ^ s3; update trellis; go TAIL_PAR.
  - TAIL_PAR: load map(z); after the third tail pair go IDLE.
- `out_last` asserted with the final parity word only.
- Output register holds value, `out_par`, `out_last` stable while `valid_out` && !`ready_out`.
- `valid_blklen` outside IDLE is ignored (no error pulse).
- `ready_bit` is 0 in IDLE, PAR, TAIL_SYS, TAIL_PAR.

## Timing
- Reset values: `out`=0, `valid_out`=0, `ready_bit`=0, `out_par`=0, `out_last`=0, `err_blklen`=0, state IDLE, trellis 000, counters 0.
- Reset mid-block: abandons the block immediately; no `out_last` is produced.
- `valid_blklen` at edge N → `ready_bit`=1 from cycle N+1.
- Bit accepted at edge N → systematic word valid from N+1; parity word valid from the edge after the systematic word is consumed.
- With `ready_out` held high: one word per cycle, one bit per 2 cycles, 2K+6 words per block (2K without tail).
- Word count = 2K + 6 (tail on); next block accepted from the cycle after the `out_last` handshake.
- Counters are 13 bits; K = 6144 completes without wrap.

## Configuration
- `RSC_TAIL_EN` defined: TAIL_SYS/TAIL_PAR active, 6 tail words appended, trellis ends in 000, `out_last` on the 6th tail word.
- Not defined: tail states removed; `out_last` on parity word of bit K; final trellis state left unterminated; 2K words per block.

## Test plan
- K=4, bits 1,0,1,1, `ready_out`=1, AMP=1024 → words −1024,−1024,+1024,−1024,−1024,+1024,−1024,−1024 then six +1024; `out_last` on word 14.
- K=1, bit 1 → −1024,−1024, tail +1024,−1024,−1024,+1024,−1024,−1024; `out_last` on word 8; trellis 000 after.
- `ready_out` toggled with a pseudo-random pattern, K=512, random bits → word sequence identical to the `ready_out`=1 run; words held stable while stalled.
- `blklen`=0 and `blklen`=6145 → one-cycle `err_blklen`, `ready_bit` stays 0; `blklen`=6144 → 12294 words, `out_last` only on the last.
- `rst` asserted after 100 bits of a K=512 block → all outputs at reset values next cycle; new K=4 block then produces the first test's exact sequence.
- Build without `RSC_TAIL_EN`, K=4 as first test → exactly 8 words, `out_last` on word 8.
